// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with KSP aliasing,
// same-cycle write bypass and a post-reset clearing FSM.
// Ports: clk, rst_n, raddr/read_no_alias/rdata/parity_err (read side),
// wen/waddr/wdata/write_no_alias (write side), kmode, stall,
// init_busy, ret_val (entry 1).
// Optional build macro: REGFILE_PARITY_EN (stored even parity + check).
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int NRD       = 2,
  parameter int NWR       = 2,
  parameter int ALIAS_REG = NREG - 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] raddr,
  input  logic [NRD-1:0]    read_no_alias,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NWR-1:0]    write_no_alias,
  input  logic              kmode,
  input  logic              stall,
  output logic              init_busy,
  output logic [NRD-1:0]    parity_err,
  output logic [XLEN-1:0]   ret_val
);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_ptr;
  logic            w_busy;

  logic [XLEN-1:0] r_mem [NREG];
  logic [XLEN-1:0] r_ksp;
  logic [NRD*XLEN-1:0] r_rdata;

  logic [AW-1:0]   w_wa [NWR];
  logic [XLEN-1:0] w_wd [NWR];
  logic [NWR-1:0]  w_wk;
  logic [NWR-1:0]  w_wv;

  logic [AW-1:0]   w_ra [NRD];
  logic [NRD-1:0]  w_rk;
  logic [NRD-1:0]  w_rz;
  logic [NRD-1:0]  w_byp;
  logic [XLEN-1:0] w_bd [NRD];
  logic [XLEN-1:0] w_stale [NRD];

  // Clear FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR)
        r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        w_busy = 1'b1;
        if (r_clr_ptr == AW'(NREG - 1))
          w_state_nxt = S_READY;
      end
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign init_busy = w_busy;

  // Write-port decode; w_wv marks a live write to a real target
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      w_wa[p] = waddr[p*AW +: AW];
      w_wd[p] = wdata[p*XLEN +: XLEN];
      w_wk[p] = kmode && !write_no_alias[p]
                && (w_wa[p] == AW'(ALIAS_REG));
      w_wv[p] = wen[p] && !w_busy
                && (w_wk[p] || (w_wa[p] != '0));
    end
  end

`ifdef REGFILE_PARITY_EN
  logic r_par [NREG];
  logic r_ksp_par;
`endif

  // Array has no reset; the clear FSM zeroes it after reset.
  // Ascending port loop: last (highest) port wins on collisions.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_ptr] <= '0;
`ifdef REGFILE_PARITY_EN
      r_par[r_clr_ptr] <= 1'b0;
`endif
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (w_wv[p] && !w_wk[p]) begin
          r_mem[w_wa[p]] <= w_wd[p];
`ifdef REGFILE_PARITY_EN
          r_par[w_wa[p]] <= ^w_wd[p];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ksp <= '0;
`ifdef REGFILE_PARITY_EN
      r_ksp_par <= 1'b0;
`endif
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (w_wv[p] && w_wk[p]) begin
          r_ksp <= w_wd[p];
`ifdef REGFILE_PARITY_EN
          r_ksp_par <= ^w_wd[p];
`endif
        end
      end
    end
  end

  // Read target resolution and bypass from the winning write
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      w_ra[i]    = raddr[i*AW +: AW];
      w_rk[i]    = kmode && !read_no_alias[i]
                   && (w_ra[i] == AW'(ALIAS_REG));
      w_rz[i]    = !w_rk[i] && (w_ra[i] == '0);
      w_stale[i] = w_rk[i] ? r_ksp : r_mem[w_ra[i]];
      w_byp[i]   = 1'b0;
      w_bd[i]    = '0;
      for (int p = 0; p < NWR; p++) begin
        if (w_wv[p] && (w_wk[p] == w_rk[i])
            && (w_rk[i] || (w_wa[p] == w_ra[i]))) begin
          w_byp[i] = 1'b1;
          w_bd[i]  = w_wd[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (!stall) begin
      for (int i = 0; i < NRD; i++) begin
        if (w_busy || w_rz[i])
          r_rdata[i*XLEN +: XLEN] <= '0;
        else if (w_byp[i])
          r_rdata[i*XLEN +: XLEN] <= w_bd[i];
        else
          r_rdata[i*XLEN +: XLEN] <= w_stale[i];
      end
    end
  end

  assign rdata = r_rdata;

`ifdef REGFILE_PARITY_EN
  logic [NRD-1:0] r_perr;
  logic           w_spar [NRD];

  always_comb begin
    for (int i = 0; i < NRD; i++)
      w_spar[i] = w_rk[i] ? r_ksp_par : r_par[w_ra[i]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= '0;
    end else if (!stall) begin
      for (int i = 0; i < NRD; i++) begin
        if (w_busy || w_rz[i] || w_byp[i])
          r_perr[i] <= 1'b0;
        else
          r_perr[i] <= (^w_stale[i]) ^ w_spar[i];
      end
    end
  end

  assign parity_err = r_perr;
`else
  assign parity_err = '0;
`endif

  // Architectural entry 1 only, never KSP, never bypassed
  assign ret_val = r_mem[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp.
// Default 32x32, 2R/2W configuration.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  raddr = '0;
  logic [1:0]  read_no_alias = '0;
  logic [63:0] rdata;
  logic [1:0]  wen = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  write_no_alias = '0;
  logic        kmode = 1'b0;
  logic        stall = 1'b0;
  logic        init_busy;
  logic [1:0]  parity_err;
  logic [31:0] ret_val;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt;

  regfile_mp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .raddr          (raddr),
    .read_no_alias  (read_no_alias),
    .rdata          (rdata),
    .wen            (wen),
    .waddr          (waddr),
    .wdata          (wdata),
    .write_no_alias (write_no_alias),
    .kmode          (kmode),
    .stall          (stall),
    .init_busy      (init_busy),
    .parity_err     (parity_err),
    .ret_val        (ret_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [4:0] a,
                    input logic [31:0] d);
    wen[p]            = 1'b1;
    waddr[p*5 +: 5]   = a;
    wdata[p*32 +: 32] = d;
  endtask

  initial begin
    #23;
    chk("rst_busy", 64'(init_busy), 64'd1);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_perr", 64'(parity_err), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      wen = '0;
      if (k == 20) wr(0, 5'd5, 32'hDEAD);
      raddr = 10'(k);
      tick();
      if (k == 10) chk("clr_rdata", rdata, 64'd0);
      if (!init_busy) begin
        cnt = k;
        break;
      end
    end
    chk("clr_cycles", 64'(cnt), 64'd32);
    wen = '0;

    raddr = {5'd6, 5'd5};
    tick();
    chk("r5_lost", rdata, 64'd0);
    for (int a = 1; a < 32; a += 6) begin
      raddr = {5'(a + 1), 5'(a)};
      tick();
      chk("zero_all", rdata, 64'd0);
    end

    wr(0, 5'd7, 32'h1234);
    tick();
    wen = '0;
    raddr = {5'd0, 5'd7};
    tick();
    chk("r7_rd", 64'(rdata[31:0]), 64'h1234);

    wr(0, 5'd0, 32'hFFFF);
    raddr = {5'd0, 5'd0};
    tick();
    chk("r0_byp", rdata, 64'd0);
    wen = '0;
    tick();
    chk("r0_rd", rdata, 64'd0);

    wr(0, 5'd3, 32'hAAAA);
    wr(1, 5'd3, 32'hBBBB);
    raddr = {5'd3, 5'd3};
    tick();
    chk("r3_byp", rdata, {32'hBBBB, 32'hBBBB});
    wen = '0;
    raddr = {5'd0, 5'd3};
    tick();
    chk("r3_rd", 64'(rdata[31:0]), 64'hBBBB);

    kmode = 1'b1;
    wr(0, 5'd31, 32'h8000);
    tick();
    wen = '0;
    raddr = {5'd31, 5'd31};
    read_no_alias = 2'b10;
    tick();
    chk("ksp_rd", rdata, {32'h0, 32'h8000});
    read_no_alias = 2'b01;
    tick();
    chk("ksp_na", rdata, {32'h8000, 32'h0});
    read_no_alias = '0;
    kmode = 1'b0;
    tick();
    chk("ksp_user", rdata, 64'd0);

    kmode = 1'b1;
    wr(1, 5'd31, 32'h9999);
    tick();
    chk("ksp_byp", rdata, {32'h9999, 32'h9999});
    wen = '0;
    wr(0, 5'd31, 32'h1111);
    write_no_alias = 2'b01;
    tick();
    wen = '0;
    write_no_alias = '0;
    kmode = 1'b0;
    tick();
    chk("wna_arr", rdata, {32'h1111, 32'h1111});
    kmode = 1'b1;
    tick();
    chk("ksp_kept", rdata, {32'h9999, 32'h9999});
    kmode = 1'b0;

    raddr = {5'd0, 5'd7};
    tick();
    chk("pre_stall", 64'(rdata[31:0]), 64'h1234);
    stall = 1'b1;
    wr(0, 5'd7, 32'h5555);
    tick();
    wen = '0;
    chk("stall1", 64'(rdata[31:0]), 64'h1234);
    tick();
    chk("stall2", 64'(rdata[31:0]), 64'h1234);
    tick();
    chk("stall3", 64'(rdata[31:0]), 64'h1234);
    stall = 1'b0;
    tick();
    chk("post_stall", 64'(rdata[31:0]), 64'h5555);

    chk("retval0", 64'(ret_val), 64'd0);
    wr(1, 5'd1, 32'h4242);
    #2;
    chk("retval_pre", 64'(ret_val), 64'd0);
    tick();
    wen = '0;
    chk("retval", 64'(ret_val), 64'h4242);

    wr(0, 5'd9, 32'h0F0F);
    wr(1, 5'd10, 32'h1237);
    tick();
    wen = '0;
`ifdef REGFILE_PARITY_EN
    dut.r_mem[9] = dut.r_mem[9] ^ 32'h1;
    raddr = {5'd10, 5'd9};
    tick();
    chk("perr_r9", 64'(parity_err), 64'b01);
    raddr = {5'd9, 5'd10};
    tick();
    chk("perr_r10", 64'(parity_err), 64'b10);
`else
    raddr = {5'd10, 5'd9};
    tick();
    chk("rd_r9_r10", rdata, {32'h1237, 32'h0F0F});
    chk("perr_off", 64'(parity_err), 64'd0);
`endif

    rst_n = 1'b0;
    #3;
    chk("rst2_busy", 64'(init_busy), 64'd1);
    chk("rst2_rdata", rdata, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
